// File: rtl/i2c_stretch_ctrl_pkg.sv
// rtl/i2c_stretch_ctrl_pkg.sv - shared types and constants for the I2C SCL stretch controller
package i2c_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HOLD  = 2'd2,
    TMO   = 2'd3
  } i2c_stretch_state_t;

  localparam logic SCL_IDLE = 1'b1;

  // Ceiling log2 for tools without a usable $clog2 in parameter context.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/i2c_stretch_ctrl_scl_sync.sv
// rtl/i2c_stretch_ctrl_scl_sync.sv - N-flop synchroniser with a selectable reset value
module i2c_scl_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic rst_val,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_ff;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_ff <= {STAGES{rst_val}};
    end else begin
      sync_ff <= {sync_ff[STAGES-2:0], d};
    end
  end

  assign q = sync_ff[STAGES-1];

endmodule

// File: rtl/i2c_stretch_ctrl.sv
// rtl/i2c_stretch_ctrl.sv - multi-channel SCL clock-stretch controller with bounded stretch
module i2c_stretch_ctrl
  import i2c_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 4096,
  parameter int CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            scl_in,
  input  logic [N_CH-1:0] pe,
  input  logic [N_CH-1:0] rbit,
  output logic            stretch_o,
  output logic [N_CH-1:0] pending_o,
  output logic            timeout_o,
  output logic            busy_o
);

  // A zero-width counter is not legal, so a disabled timeout still keeps one bit.
  localparam int             CW       = (CNT_W < 1) ? 1 : CNT_W;
  localparam logic           TMO_EN   = (TIMEOUT_CYC != 0);
  localparam logic [CW-1:0]  CNT_LAST = TMO_EN ? CW'(TIMEOUT_CYC - 1) : '0;
  localparam logic [CW-1:0]  CNT_MAX  = '1;

  i2c_stretch_state_t state, state_next;
  logic [N_CH-1:0]    pending;
  logic [CW-1:0]      cnt;
  logic               tmo_first;
  logic               any_pend;
  logic               scl_s;

  i2c_scl_sync #(
    .STAGES (SYNC_STAGES)
  ) u_scl_sync (
    .clk     (clk),
    .reset   (reset),
    .rst_val (SCL_IDLE),
    .d       (scl_in),
    .q       (scl_s)
  );

  // Set strobe takes priority over release on the same channel.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~rbit) | pe;
    end
  end

  assign any_pend = |pending;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // HOLD is only reachable from ARMED with SCL already low, so our own drive
  // holding scl_s at 0 can never re-enter a stretch by itself.
  always_comb begin
    state_next = state;
    if (!en) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (any_pend) state_next = ARMED;
        end
        ARMED: begin
          if (!any_pend)   state_next = IDLE;
          else if (!scl_s) state_next = HOLD;
        end
        HOLD: begin
          if (!any_pend)                     state_next = IDLE;
          else if (TMO_EN && cnt == CNT_LAST) state_next = TMO;
        end
        TMO: begin
          if (scl_s) state_next = any_pend ? ARMED : IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      tmo_first <= 1'b0;
    end else begin
      if (state == HOLD && state_next == HOLD) begin
        if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
      tmo_first <= (state_next == TMO) && (state != TMO);
    end
  end

  always_comb begin
    stretch_o = (state == HOLD);
    busy_o    = (state != IDLE);
    timeout_o = (state == TMO) && tmo_first;
    pending_o = pending;
  end

endmodule

// File: tb/tb_i2c_stretch_ctrl.sv
// tb/tb_i2c_stretch_ctrl.sv - directed scoreboard bench for i2c_stretch_ctrl
module tb_i2c_stretch_ctrl;

  logic       clk;
  logic       reset;
  logic       en;
  logic       scl_in;
  logic [3:0] pe;
  logic [3:0] rbit;
  logic       stretch_o;
  logic [3:0] pending_o;
  logic       timeout_o;
  logic       busy_o;

  int total;
  int bad;
  logic [6:0] exp_q[$];

  i2c_stretch_ctrl #(
    .N_CH        (4),
    .SYNC_STAGES (2),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .scl_in    (scl_in),
    .pe        (pe),
    .rbit      (rbit),
    .stretch_o (stretch_o),
    .pending_o (pending_o),
    .timeout_o (timeout_o),
    .busy_o    (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] ev(input logic s, input logic b, input logic t, input logic [3:0] p);
    return {s, b, t, p};
  endfunction

  task automatic push(input logic [6:0] e);
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observed vector is {stretch, busy, timeout, pending[3:0]}.
  task automatic chk(input string tag);
    logic [6:0] obs;
    logic [6:0] exp;
    obs = {stretch_o, busy_o, timeout_o, pending_o};
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s: scoreboard empty, observed=%b", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        bad++;
        $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
    end
  endtask

  task automatic step_chk(input string tag, input logic [6:0] e);
    push(e);
    tick();
    chk(tag);
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    reset  = 1'b1;
    en     = 1'b1;
    scl_in = 1'b0;
    pe     = '0;
    rbit   = '0;
    tick();
    step_chk("reset_state", ev(0, 0, 0, 4'b0000));

    // SCL already low: pending next edge, stretch two edges after that.
    reset = 1'b0;
    pe    = 4'b0010;
    step_chk("pe_to_pending", ev(0, 0, 0, 4'b0010));
    pe = '0;
    step_chk("idle_to_armed", ev(0, 1, 0, 4'b0010));
    step_chk("armed_to_hold", ev(1, 1, 0, 4'b0010));
    rbit = 4'b0010;
    step_chk("release_edge1", ev(1, 1, 0, 4'b0000));
    rbit = '0;
    step_chk("release_edge2", ev(0, 0, 0, 4'b0000));

    // SCL high: arm but never stretch until SCL falls.
    scl_in = 1'b1;
    tick();
    tick();
    step_chk("idle_scl_high", ev(0, 0, 0, 4'b0000));
    pe = 4'b0001;
    step_chk("pe_scl_high", ev(0, 0, 0, 4'b0001));
    pe = '0;
    step_chk("armed_scl_high", ev(0, 1, 0, 4'b0001));
    step_chk("armed_hold_off", ev(0, 1, 0, 4'b0001));
    scl_in = 1'b0;
    step_chk("scl_fall_edge1", ev(0, 1, 0, 4'b0001));
    step_chk("scl_fall_edge2", ev(0, 1, 0, 4'b0001));
    step_chk("scl_fall_edge3", ev(1, 1, 0, 4'b0001));

    // Same-cycle set and release: set wins.
    pe   = 4'b0100;
    rbit = 4'b0100;
    step_chk("pe_wins", ev(1, 1, 0, 4'b0101));
    pe   = 4'b0001;
    rbit = 4'b0100;
    step_chk("mixed_strobe", ev(1, 1, 0, 4'b0001));
    pe   = '0;
    rbit = '0;

    // Stretch lasts exactly 8 cycles in total, then one timeout pulse.
    for (int i = 3; i < 8; i++) begin
      step_chk($sformatf("hold_cycle%0d", i), ev(1, 1, 0, 4'b0001));
    end
    step_chk("timeout_pulse", ev(0, 1, 1, 4'b0001));
    step_chk("tmo_wait", ev(0, 1, 0, 4'b0001));

    scl_in = 1'b1;
    step_chk("tmo_scl_rise1", ev(0, 1, 0, 4'b0001));
    step_chk("tmo_scl_rise2", ev(0, 1, 0, 4'b0001));
    step_chk("tmo_to_armed", ev(0, 1, 0, 4'b0001));
    scl_in = 1'b0;
    step_chk("restretch_edge1", ev(0, 1, 0, 4'b0001));
    step_chk("restretch_edge2", ev(0, 1, 0, 4'b0001));
    step_chk("restretch_edge3", ev(1, 1, 0, 4'b0001));

    // Disable mid-stretch keeps pending; re-enable stretches again.
    en = 1'b0;
    step_chk("en_off_release", ev(0, 0, 0, 4'b0001));
    step_chk("en_off_idle", ev(0, 0, 0, 4'b0001));
    en = 1'b1;
    step_chk("en_on_armed", ev(0, 1, 0, 4'b0001));
    step_chk("en_on_hold", ev(1, 1, 0, 4'b0001));

    // Reset mid-stretch releases and clears pending.
    reset = 1'b1;
    step_chk("reset_mid_hold", ev(0, 0, 0, 4'b0000));
    reset = 1'b0;
    step_chk("post_reset_idle", ev(0, 0, 0, 4'b0000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
